// File: rtl/step_pulse_debouncer.sv
// rtl/step_pulse_debouncer.sv - push-button synchroniser/debouncer emitting single-cycle step pulses
// with press qualification, auto-repeat while held, and a wrapping pulse counter.
module step_pulse_debouncer #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             btn_in,
  output logic             step,
  output logic             btn_level,
  output logic             repeat_active,
  output logic [CNT_W-1:0] press_count
);

  localparam int RMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int DW   = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES);
  localparam logic [RW-1:0] DELAY_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST  = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    REL_CHK   = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            s1, btn_s;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [RW-1:0]   rcnt, rcnt_n;
  logic            step_n, level_n;

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    rcnt_n  = rcnt;
    step_n  = 1'b0;
    level_n = btn_level;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_CHK;
          dcnt_n  = DW'(1);
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (dcnt == DEB_LAST) begin
          state_n = HELD;
          step_n  = 1'b1;
          level_n = 1'b1;
          rcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = REL_CHK;
          dcnt_n  = DW'(1);
        end else if (rcnt == DELAY_LAST) begin
          state_n = REPEAT;
          step_n  = 1'b1;
          rcnt_n  = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_n = REL_CHK;
          dcnt_n  = DW'(1);
        end else if (rcnt == PERIOD_LAST) begin
          step_n = 1'b1;
          rcnt_n = '0;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end
      REL_CHK: begin
        // A bounce back high resumes holding without re-issuing the press step
        if (btn_s) begin
          state_n = HELD;
          rcnt_n  = '0;
        end else if (dcnt == DEB_LAST) begin
          state_n = IDLE;
          level_n = 1'b0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1            <= 1'b0;
      btn_s         <= 1'b0;
      state         <= IDLE;
      dcnt          <= '0;
      rcnt          <= '0;
      step          <= 1'b0;
      btn_level     <= 1'b0;
      repeat_active <= 1'b0;
      press_count   <= '0;
    end else begin
      s1            <= btn_in;
      btn_s         <= s1;
      state         <= state_n;
      dcnt          <= dcnt_n;
      rcnt          <= rcnt_n;
      step          <= step_n;
      btn_level     <= level_n;
      repeat_active <= (state_n == REPEAT);
      if (step_n) press_count <= press_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_step_pulse_debouncer.sv
// tb/tb_step_pulse_debouncer.sv - directed self-checking bench for step_pulse_debouncer
module tb_step_pulse_debouncer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       btn_in;
  logic       step, btn_level, repeat_active;
  logic [7:0] press_count;
  logic       step2, level2, ract2;
  logic [1:0] pc2;
  logic [1:0] seq_q;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  step_pulse_debouncer dut (
    .CLK(CLK), .RST(RST), .btn_in(btn_in), .step(step), .btn_level(btn_level),
    .repeat_active(repeat_active), .press_count(press_count)
  );

  step_pulse_debouncer #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .btn_in(btn_in), .step(step2), .btn_level(level2),
    .repeat_active(ract2), .press_count(pc2)
  );

  // Downstream 2-bit Moore sequencer: 00 -> 10 -> 11 -> 01 -> 00, y=1 only in 11
  always_ff @(posedge CLK) begin
    if (RST) seq_q <= 2'b00;
    else if (step2) begin
      case (seq_q)
        2'b00:   seq_q <= 2'b10;
        2'b10:   seq_q <= 2'b11;
        2'b11:   seq_q <= 2'b01;
        default: seq_q <= 2'b00;
      endcase
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    btn_in = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    btn_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({step, btn_level, repeat_active} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000", {step, btn_level, repeat_active});
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_press_count got=%0d exp=0", press_count);
    end
    checks++;
    if (pc2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_press_count_w2 got=%0d exp=0", pc2);
    end
    btn_in = 1'b0;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_clean_press;
    logic exp_step, exp_level;
    do_reset();
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_step  = (i == 6);
      exp_level = (i >= 6);
      checks++;
      if (step !== exp_step) begin
        errors++;
        $display("FAIL t1_step cyc=%0d got=%b exp=%b", i, step, exp_step);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL t1_level cyc=%0d got=%b exp=%b", i, btn_level, exp_level);
      end
    end
    btn_in = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      exp_level = (j < 6);
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL t1_release_step cyc=%0d got=%b exp=0", j, step);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL t1_release_level cyc=%0d got=%b exp=%b", j, btn_level, exp_level);
      end
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++;
      $display("FAIL t1_press_count got=%0d exp=1", press_count);
    end
  endtask

  task automatic test_bounce;
    int nsteps;
    logic [3:0] pattern;
    pattern = 4'b1010;
    nsteps = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      btn_in = (i < 4) ? pattern[3 - i] : 1'b0;
      tick();
      if (step) nsteps++;
      checks++;
      if (btn_level !== 1'b0) begin
        errors++;
        $display("FAIL t2_level cyc=%0d got=%b exp=0", i, btn_level);
      end
    end
    checks++;
    if (nsteps !== 0) begin
      errors++;
      $display("FAIL t2_steps got=%0d exp=0", nsteps);
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL t2_press_count got=%0d exp=0", press_count);
    end
  endtask

  task automatic test_auto_repeat;
    logic exp_step, exp_ract, exp_level;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      btn_in = (i < 60);
      tick();
      exp_step  = (i == 6) || (i == 22) || (i == 30) || (i == 38) || (i == 46) || (i == 54);
      exp_ract  = (i >= 22) && (i < 62);
      exp_level = (i >= 6) && (i < 66);
      checks++;
      if (step !== exp_step) begin
        errors++;
        $display("FAIL t3_step cyc=%0d got=%b exp=%b", i, step, exp_step);
      end
      checks++;
      if (repeat_active !== exp_ract) begin
        errors++;
        $display("FAIL t3_repeat_active cyc=%0d got=%b exp=%b", i, repeat_active, exp_ract);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL t3_level cyc=%0d got=%b exp=%b", i, btn_level, exp_level);
      end
    end
    checks++;
    if (press_count !== 8'd6) begin
      errors++;
      $display("FAIL t3_press_count got=%0d exp=6", press_count);
    end
  endtask

  task automatic test_release_bounce;
    logic exp_step, exp_level, exp_ract;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      btn_in = !((i == 10) || (i == 11));
      tick();
      exp_step  = (i == 6) || (i == 30);
      exp_level = (i >= 6);
      exp_ract  = (i >= 30);
      checks++;
      if (step !== exp_step) begin
        errors++;
        $display("FAIL t4_step cyc=%0d got=%b exp=%b", i, step, exp_step);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL t4_level cyc=%0d got=%b exp=%b", i, btn_level, exp_level);
      end
      checks++;
      if (repeat_active !== exp_ract) begin
        errors++;
        $display("FAIL t4_repeat_active cyc=%0d got=%b exp=%b", i, repeat_active, exp_ract);
      end
    end
  endtask

  task automatic test_reset_mid_press;
    logic exp_step, exp_level;
    do_reset();
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({step, btn_level, repeat_active, press_count} !== 11'd0) begin
      errors++;
      $display("FAIL t5_reset_outputs got=%b exp=0", {step, btn_level, repeat_active, press_count});
    end
    RST = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      exp_step  = (j == 6);
      exp_level = (j >= 6);
      checks++;
      if (step !== exp_step) begin
        errors++;
        $display("FAIL t5_step cyc=%0d got=%b exp=%b", j, step, exp_step);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL t5_level cyc=%0d got=%b exp=%b", j, btn_level, exp_level);
      end
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++;
      $display("FAIL t5_press_count got=%0d exp=1", press_count);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_pc  [5];
    logic [1:0] exp_seq [5];
    logic       exp_y;
    exp_pc  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      btn_in = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      btn_in = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      checks++;
      if (pc2 !== exp_pc[p]) begin
        errors++;
        $display("FAIL t6_press_count_w2 press=%0d got=%0d exp=%0d", p, pc2, exp_pc[p]);
      end
      checks++;
      if (press_count !== 8'(p + 1)) begin
        errors++;
        $display("FAIL t6_press_count_w8 press=%0d got=%0d exp=%0d", p, press_count, p + 1);
      end
      checks++;
      if (seq_q !== exp_seq[p]) begin
        errors++;
        $display("FAIL t6_seq_state press=%0d got=%b exp=%b", p, seq_q, exp_seq[p]);
      end
      exp_y = (p == 1);
      checks++;
      if ((seq_q == 2'b11) !== exp_y) begin
        errors++;
        $display("FAIL t6_seq_y press=%0d got=%b exp=%b", p, (seq_q == 2'b11), exp_y);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_bounce();
    test_reset_mid_press();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
